// File: rtl/status_flag_register.sv
// status_flag_register
// Architectural status register fed by the ALU flag generator. Holds the
// {N,Z,C,V} flags and the last ALU result, accumulates sticky carry/overflow
// and a saturating overflow event count, and evaluates 4-bit condition codes
// against the registered flags through a one-cycle req/ack handshake.
module status_flag_register #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flag_valid,
  input  logic                 zero_in,
  input  logic                 carry_in,
  input  logic                 overflow_in,
  input  logic                 negative_in,
  input  logic                 is_arithmetic,
  input  logic [WIDTH-1:0]     result_in,
  input  logic                 flags_we,
  input  logic [3:0]           flags_wdata,
  input  logic                 sticky_clr,
  input  logic                 cond_req,
  input  logic [3:0]           cond_sel,
  output logic [3:0]           flags_q,
  output logic [WIDTH-1:0]     result_q,
  output logic                 flags_vld,
  output logic                 sticky_c,
  output logic                 sticky_v,
  output logic [CNT_WIDTH-1:0] ovf_count,
  output logic                 cond_ack,
  output logic                 cond_true
);

  // Bit positions inside the {N,Z,C,V} flag vector.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // The overflow counter parks here instead of wrapping.
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // Condition code encoding used by branch/predication logic.
  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  // Qualified ALU events; only arithmetic ops feed the sticky bits and counter.
  logic arith_op;
  logic ovf_event;
  logic carry_event;

  assign arith_op    = flag_valid & is_arithmetic;
  assign ovf_event   = arith_op & overflow_in;
  assign carry_event = arith_op & carry_in;

  // Next-state values for every register.
  logic [3:0]           flags_d;
  logic [WIDTH-1:0]     result_d;
  logic                 flags_vld_d;
  logic                 sticky_c_d;
  logic                 sticky_v_d;
  logic [CNT_WIDTH-1:0] ovf_count_d;
  logic                 cond_ack_d;
  logic                 cond_true_d;
  logic                 cond_eval;

  // Flag and result capture: direct write beats the ALU for flags_q only.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    flags_d     = flags_q;
    result_d    = result_q;
    flags_vld_d = flags_vld | flags_we | flag_valid;

    if (flag_valid) begin
      result_d = result_in;
    end

    if (flags_we) begin
      flags_d = flags_wdata;
    end else if (flag_valid) begin
      flags_d[FLAG_N] = negative_in;
      flags_d[FLAG_Z] = zero_in;
      // Logic ops leave carry and overflow untouched.
      if (is_arithmetic) begin
        flags_d[FLAG_C] = carry_in;
        flags_d[FLAG_V] = overflow_in;
      end
    end
  end

  // Sticky bits and saturating overflow counter; a new event beats a clear.
  always_comb begin
    sticky_c_d  = (sticky_c & ~sticky_clr) | carry_event;
    sticky_v_d  = (sticky_v & ~sticky_clr) | ovf_event;
    ovf_count_d = ovf_count;

    if (sticky_clr) begin
      ovf_count_d = ovf_event ? CNT_WIDTH'(1) : '0;
    end else if (ovf_event && (ovf_count != CNT_MAX)) begin
      ovf_count_d = ovf_count + CNT_WIDTH'(1);
    end
  end

  // Condition evaluation against the registered flags (no same-cycle bypass).
  always_comb begin
    cond_eval = 1'b0;
    unique case (cond_e'(cond_sel))
      COND_EQ: cond_eval =  flags_q[FLAG_Z];
      COND_NE: cond_eval = ~flags_q[FLAG_Z];
      COND_CS: cond_eval =  flags_q[FLAG_C];
      COND_CC: cond_eval = ~flags_q[FLAG_C];
      COND_MI: cond_eval =  flags_q[FLAG_N];
      COND_PL: cond_eval = ~flags_q[FLAG_N];
      COND_VS: cond_eval =  flags_q[FLAG_V];
      COND_VC: cond_eval = ~flags_q[FLAG_V];
      COND_HI: cond_eval =  flags_q[FLAG_C] & ~flags_q[FLAG_Z];
      COND_LS: cond_eval = ~flags_q[FLAG_C] |  flags_q[FLAG_Z];
      COND_GE: cond_eval =  (flags_q[FLAG_N] == flags_q[FLAG_V]);
      COND_LT: cond_eval =  (flags_q[FLAG_N] != flags_q[FLAG_V]);
      COND_GT: cond_eval = ~flags_q[FLAG_Z] & (flags_q[FLAG_N] == flags_q[FLAG_V]);
      COND_LE: cond_eval =  flags_q[FLAG_Z] | (flags_q[FLAG_N] != flags_q[FLAG_V]);
      COND_AL: cond_eval = 1'b1;
      COND_NV: cond_eval = 1'b0;
      default: cond_eval = 1'b0;
    endcase
  end

  // Handshake: ack pulses the cycle after each request; result holds otherwise.
  always_comb begin
    cond_ack_d  = cond_req;
    cond_true_d = cond_req ? cond_eval : cond_true;
  end

  // State register with synchronous active-low reset overriding all inputs.
  always_ff @(posedge clk) begin
    // NOTE: the reset is sampled on the clock edge, so it sits inside the
    // edge-triggered block rather than in the sensitivity list; all state here
    // is plain flops (no arrays), so every register is cleared.
    if (!rst_n) begin
      // NOTE: non-blocking assignments keep every flop reading pre-edge values.
      flags_q   <= '0;
      result_q  <= '0;
      flags_vld <= 1'b0;
      sticky_c  <= 1'b0;
      sticky_v  <= 1'b0;
      ovf_count <= '0;
      cond_ack  <= 1'b0;
      cond_true <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      result_q  <= result_d;
      flags_vld <= flags_vld_d;
      sticky_c  <= sticky_c_d;
      sticky_v  <= sticky_v_d;
      ovf_count <= ovf_count_d;
      cond_ack  <= cond_ack_d;
      cond_true <= cond_true_d;
    end
  end

endmodule

// File: tb/tb_status_flag_register.sv
// Directed testbench for status_flag_register with hand-computed expectations.
module tb_status_flag_register;

  localparam int WIDTH     = 4;
  localparam int CNT_WIDTH = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 flag_valid;
  logic                 zero_in;
  logic                 carry_in;
  logic                 overflow_in;
  logic                 negative_in;
  logic                 is_arithmetic;
  logic [WIDTH-1:0]     result_in;
  logic                 flags_we;
  logic [3:0]           flags_wdata;
  logic                 sticky_clr;
  logic                 cond_req;
  logic [3:0]           cond_sel;
  logic [3:0]           flags_q;
  logic [WIDTH-1:0]     result_q;
  logic                 flags_vld;
  logic                 sticky_c;
  logic                 sticky_v;
  logic [CNT_WIDTH-1:0] ovf_count;
  logic                 cond_ack;
  logic                 cond_true;

  int vectors     = 0;
  int miscompares = 0;

  status_flag_register #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flag_valid    (flag_valid),
    .zero_in       (zero_in),
    .carry_in      (carry_in),
    .overflow_in   (overflow_in),
    .negative_in   (negative_in),
    .is_arithmetic (is_arithmetic),
    .result_in     (result_in),
    .flags_we      (flags_we),
    .flags_wdata   (flags_wdata),
    .sticky_clr    (sticky_clr),
    .cond_req      (cond_req),
    .cond_sel      (cond_sel),
    .flags_q       (flags_q),
    .result_q      (result_q),
    .flags_vld     (flags_vld),
    .sticky_c      (sticky_c),
    .sticky_v      (sticky_v),
    .ovf_count     (ovf_count),
    .cond_ack      (cond_ack),
    .cond_true     (cond_true)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle just past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drop every strobe back to idle.
  task automatic idle();
    flag_valid    = 1'b0;
    flags_we      = 1'b0;
    sticky_clr    = 1'b0;
    cond_req      = 1'b0;
    is_arithmetic = 1'b0;
    negative_in   = 1'b0;
    zero_in       = 1'b0;
    carry_in      = 1'b0;
    overflow_in   = 1'b0;
    result_in     = '0;
    flags_wdata   = '0;
    cond_sel      = '0;
  endtask

  task automatic alu_op(input logic arith, input logic n, input logic z,
                        input logic c, input logic v, input logic [WIDTH-1:0] res);
    flag_valid    = 1'b1;
    is_arithmetic = arith;
    negative_in   = n;
    zero_in       = z;
    carry_in      = c;
    overflow_in   = v;
    result_in     = res;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".flags_q"},   32'(flags_q),   32'h0);
    check({tag, ".result_q"},  32'(result_q),  32'h0);
    check({tag, ".flags_vld"}, 32'(flags_vld), 32'h0);
    check({tag, ".sticky_c"},  32'(sticky_c),  32'h0);
    check({tag, ".sticky_v"},  32'(sticky_v),  32'h0);
    check({tag, ".ovf_count"}, 32'(ovf_count), 32'h0);
    check({tag, ".cond_ack"},  32'(cond_ack),  32'h0);
    check({tag, ".cond_true"}, 32'(cond_true), 32'h0);
  endtask

  // Stream all 16 condition codes back-to-back, one ack per cycle.
  task automatic sweep_conds(input string tag, input logic [15:0] expected_bits);
    logic [15:0] exp_bits;
    exp_bits = expected_bits;
    for (int i = 0; i < 16; i++) begin
      cond_req = 1'b1;
      cond_sel = 4'(i);
      tick();
      check($sformatf("%s.ack[%0d]", tag, i), 32'(cond_ack), 32'h1);
      check($sformatf("%s.true[%0d]", tag, i), 32'(cond_true), 32'(exp_bits[i]));
    end
    idle();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;

    // Reset state.
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();
    check("idle.flags_vld", 32'(flags_vld), 32'h0);
    check("idle.cond_ack",  32'(cond_ack),  32'h0);

    // Arithmetic capture N=1 Z=0 C=1 V=1, result 9.
    alu_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h9);
    tick();
    idle();
    check("arith.flags_q",   32'(flags_q),   32'hB);
    check("arith.result_q",  32'(result_q),  32'h9);
    check("arith.sticky_c",  32'(sticky_c),  32'h1);
    check("arith.sticky_v",  32'(sticky_v),  32'h1);
    check("arith.ovf_count", 32'(ovf_count), 32'h1);
    check("arith.flags_vld", 32'(flags_vld), 32'h1);

    // Logic op N=0 Z=1: C and V hold.
    alu_op(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h3);
    tick();
    idle();
    check("logic.flags_q",   32'(flags_q),   32'h7);
    check("logic.result_q",  32'(result_q),  32'h3);
    check("logic.ovf_count", 32'(ovf_count), 32'h1);

    // Plain sticky clear.
    sticky_clr = 1'b1;
    tick();
    idle();
    check("clr.sticky_c",  32'(sticky_c),  32'h0);
    check("clr.sticky_v",  32'(sticky_v),  32'h0);
    check("clr.ovf_count", 32'(ovf_count), 32'h0);

    // Logic op with carry/overflow asserted must not touch sticky or counter.
    alu_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'hA);
    carry_in = 1'b1;
    tick();
    idle();
    check("logicovf.flags_q",   32'(flags_q),   32'hB);
    check("logicovf.sticky_c",  32'(sticky_c),  32'h0);
    check("logicovf.sticky_v",  32'(sticky_v),  32'h0);
    check("logicovf.ovf_count", 32'(ovf_count), 32'h0);

    // 300 overflowing arithmetic ops: counter saturates at 255.
    for (int i = 0; i < 255; i++) begin
      alu_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'(i));
      tick();
    end
    check("sat.ovf_count_255", 32'(ovf_count), 32'd255);
    for (int i = 0; i < 45; i++) begin
      alu_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'(i));
      tick();
    end
    idle();
    check("sat.ovf_count_300", 32'(ovf_count), 32'd255);
    check("sat.sticky_v",      32'(sticky_v),  32'h1);
    check("sat.sticky_c",      32'(sticky_c),  32'h0);

    // Clear concurrent with an overflow event: set wins, count restarts at 1.
    alu_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2);
    sticky_clr = 1'b1;
    tick();
    idle();
    check("clrset.sticky_v",  32'(sticky_v),  32'h1);
    check("clrset.sticky_c",  32'(sticky_c),  32'h0);
    check("clrset.ovf_count", 32'(ovf_count), 32'h1);

    // Direct write collides with capture: write wins flags, result still updates.
    alu_op(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h5);
    flags_we    = 1'b1;
    flags_wdata = 4'b0001;
    tick();
    idle();
    check("we.flags_q",   32'(flags_q),   32'h1);
    check("we.result_q",  32'(result_q),  32'h5);
    check("we.sticky_c",  32'(sticky_c),  32'h1);
    check("we.ovf_count", 32'(ovf_count), 32'h1);

    // Signed-compare conditions with N=1 V=1.
    flags_we    = 1'b1;
    flags_wdata = 4'b1001;
    tick();
    idle();
    check("cond.flags_q", 32'(flags_q), 32'h9);
    for (int i = 0; i < 6; i++) begin
      cond_req = 1'b1;
      cond_sel = 4'(4'hA + i);
      tick();
      check($sformatf("cond_nv.ack[%0d]", i), 32'(cond_ack), 32'h1);
      // GE,LT,GT,LE,AL,NV -> 1,0,1,0,1,0
      check($sformatf("cond_nv.true[%0d]", i), 32'(cond_true), 32'((i % 2) == 0));
    end
    idle();

    // Request in the same cycle as a capture sees the old flags (Z=0).
    alu_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    cond_req = 1'b1;
    cond_sel = 4'h0;
    tick();
    idle();
    check("nobypass.cond_true", 32'(cond_true), 32'h0);
    check("nobypass.flags_q",   32'(flags_q),   32'h4);
    cond_req = 1'b1;
    cond_sel = 4'h0;
    tick();
    idle();
    check("eq_after.cond_true", 32'(cond_true), 32'h1);
    tick();
    check("hold.cond_ack",  32'(cond_ack),  32'h0);
    check("hold.cond_true", 32'(cond_true), 32'h1);

    // Full code sweep with Z=1 C=1, then N=1 alone.
    flags_we    = 1'b1;
    flags_wdata = 4'b0110;
    tick();
    idle();
    sweep_conds("sweep_zc", 16'h66A5);
    flags_we    = 1'b1;
    flags_wdata = 4'b1000;
    tick();
    idle();
    sweep_conds("sweep_n", 16'h6A9A);

    // Reset mid-stream while a request is in flight.
    alu_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'hE);
    tick();
    idle();
    cond_req = 1'b1;
    cond_sel = 4'hE;
    tick();
    check("pre_rst.cond_ack",  32'(cond_ack),  32'h1);
    check("pre_rst.cond_true", 32'(cond_true), 32'h1);
    rst_n = 1'b0;
    tick();
    check_all_zero("midrst");
    rst_n = 1'b1;
    idle();
    tick();
    check("post_rst.cond_ack",  32'(cond_ack),  32'h0);
    check("post_rst.flags_vld", 32'(flags_vld), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
